sobel_scan_ctrl: RTL and testbench

SOBEL_SCAN_CTRL -- requirements
Module: sobel_scan_ctrl

---
 rtl/sobel_scan_ctrl_if.sv | 48 ++++
 rtl/sobel_scan_ctrl.sv | 125 ++++++++++++
 tb/tb_sobel_scan_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/sobel_scan_ctrl_if.sv
// Handshake and status bundle for the Sobel raster-scan controller.
// The master is the upstream pixel source; the slave is the controller itself.
interface sobel_scan_ctrl_if #(
    parameter int DIM_BITS = 10
);
    logic                start;
    logic                abort;
    logic [DIM_BITS-1:0] img_width;
    logic [DIM_BITS-1:0] img_height;
    logic                pixel_valid;
    logic                pixel_ready;
    logic [DIM_BITS-1:0] col;
    logic [DIM_BITS-1:0] row;
    logic                window_valid;
    logic                busy;
    logic                frame_done;
    logic                cfg_err;

    modport master (
        output start,
        output abort,
        output img_width,
        output img_height,
        output pixel_valid,
        input  pixel_ready,
        input  col,
        input  row,
        input  window_valid,
        input  busy,
        input  frame_done,
        input  cfg_err
    );

    modport slave (
        input  start,
        input  abort,
        input  img_width,
        input  img_height,
        input  pixel_valid,
        output pixel_ready,
        output col,
        output row,
        output window_valid,
        output busy,
        output frame_done,
        output cfg_err
    );
endinterface

// File: rtl/sobel_scan_ctrl.sv
// Raster-scan controller for a 3x3 Sobel window: tracks the pixel position in a
// frame and flags every accepted pixel that closes a complete 3x3 neighbourhood.
module sobel_scan_ctrl #(
    parameter int DIM_BITS = 10
) (
    input logic              clk,
    input logic              n_rst,
    sobel_scan_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [DIM_BITS-1:0] width_q, width_d;
    logic [DIM_BITS-1:0] height_q, height_d;
    logic [DIM_BITS-1:0] col_q, col_d;
    logic [DIM_BITS-1:0] row_q, row_d;
    logic                window_valid_q, window_valid_d;
    logic                cfg_err_q, cfg_err_d;

    logic in_frame;
    logic accept;
    logic dims_ok;
    logic col_last;
    logic row_last;

    assign in_frame = (state_q == FILL) || (state_q == RUN);
    assign accept   = bus.pixel_valid && in_frame;
    assign dims_ok  = (bus.img_width >= DIM_BITS'(3)) && (bus.img_height >= DIM_BITS'(3));
    assign col_last = (col_q == width_q - DIM_BITS'(1));
    assign row_last = (row_q == height_q - DIM_BITS'(1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q        <= IDLE;
            width_q        <= '0;
            height_q       <= '0;
            col_q          <= '0;
            row_q          <= '0;
            window_valid_q <= 1'b0;
            cfg_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            width_q        <= width_d;
            height_q       <= height_d;
            col_q          <= col_d;
            row_q          <= row_d;
            window_valid_q <= window_valid_d;
            cfg_err_q      <= cfg_err_d;
        end
    end

    // Abort outranks everything, including an accept in the same cycle, so a
    // cancelled frame never emits a trailing window or completion pulse.
    always_comb begin
        state_d        = state_q;
        width_d        = width_q;
        height_d       = height_q;
        col_d          = col_q;
        row_d          = row_q;
        window_valid_d = 1'b0;
        cfg_err_d      = 1'b0;

        if (bus.abort) begin
            state_d = IDLE;
            col_d   = '0;
            row_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (dims_ok) begin
                            width_d  = bus.img_width;
                            height_d = bus.img_height;
                            col_d    = '0;
                            row_d    = '0;
                            state_d  = FILL;
                        end else begin
                            cfg_err_d = 1'b1;
                        end
                    end
                end
                FILL, RUN: begin
                    if (accept) begin
                        window_valid_d = (row_q >= DIM_BITS'(2)) && (col_q >= DIM_BITS'(2));
                        if (col_last) begin
                            col_d = '0;
                            if ((state_q == RUN) && row_last) begin
                                row_d   = '0;
                                state_d = DONE;
                            end else begin
                                row_d = row_q + DIM_BITS'(1);
                                if ((state_q == FILL) && (row_q == DIM_BITS'(1))) begin
                                    state_d = RUN;
                                end
                            end
                        end else begin
                            col_d = col_q + DIM_BITS'(1);
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.pixel_ready  = in_frame;
        bus.busy         = in_frame;
        bus.frame_done   = (state_q == DONE);
        bus.window_valid = window_valid_q;
        bus.cfg_err      = cfg_err_q;
        bus.col          = col_q;
        bus.row          = row_q;
    end
endmodule

// File: tb/tb_sobel_scan_ctrl.sv
// Self-checking bench for sobel_scan_ctrl: a vector table for reset, config
// rejection and a minimal frame, then scoreboarded frames and corner sequences.
module tb_sobel_scan_ctrl;
    localparam int DB = 10;

    logic clk = 1'b0;
    logic n_rst;

    sobel_scan_ctrl_if #(.DIM_BITS(DB)) bus ();

    sobel_scan_ctrl #(.DIM_BITS(DB)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit wv_q[$];

    typedef struct {
        logic          start;
        logic          abort;
        logic          pv;
        logic [DB-1:0] w;
        logic [DB-1:0] h;
        logic          ready;
        logic          busy;
        logic [DB-1:0] col;
        logic [DB-1:0] row;
        logic          wv;
        logic          fd;
        logic          err;
    } vec_t;

    vec_t vecs[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic a, input logic pv, input int w, input int h);
        bus.start       = s;
        bus.abort       = a;
        bus.pixel_valid = pv;
        bus.img_width   = DB'(w);
        bus.img_height  = DB'(h);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAll(input string tag, input logic ready, input logic busy, input int col,
                            input int row, input logic wv, input logic fd, input logic err);
        checkOutput({tag, "_ready"}, 32'(bus.pixel_ready), 32'(ready));
        checkOutput({tag, "_busy"}, 32'(bus.busy), 32'(busy));
        checkOutput({tag, "_col"}, 32'(bus.col), col);
        checkOutput({tag, "_row"}, 32'(bus.row), row);
        checkOutput({tag, "_wv"}, 32'(bus.window_valid), 32'(wv));
        checkOutput({tag, "_fd"}, 32'(bus.frame_done), 32'(fd));
        checkOutput({tag, "_err"}, 32'(bus.cfg_err), 32'(err));
    endtask

    function automatic void addVec(input logic s, input logic a, input logic pv, input int w, input int h,
                                   input logic ready, input logic busy, input int col, input int row,
                                   input logic wv, input logic fd, input logic err);
        vec_t v;
        v.start = s;   v.abort = a;  v.pv  = pv;
        v.w     = DB'(w); v.h = DB'(h);
        v.ready = ready; v.busy = busy;
        v.col   = DB'(col); v.row = DB'(row);
        v.wv    = wv;  v.fd   = fd;  v.err = err;
        vecs.push_back(v);
    endfunction

    // pattern: 0 = continuous valid, 1 = valid every other cycle, 2 = random valid.
    task automatic runFrame(input string tag, input int w, input int h, input int pattern, input bit midStart);
        int  expC = 0;
        int  expR = 0;
        int  accepts = 0;
        int  pulses = 0;
        int  cyc = 0;
        int  budget = 4 * w * h + 20;
        bit  pv;
        bit  expWv;
        wv_q.delete();

        applyStimulus(1'b1, 1'b0, 1'b0, w, h);
        tick();
        checkOutput({tag, "_start_busy"}, 32'(bus.busy), 1);
        checkOutput({tag, "_start_col"}, 32'(bus.col), 0);
        checkOutput({tag, "_start_row"}, 32'(bus.row), 0);

        while (accepts < w * h && cyc < budget) begin
            case (pattern)
                1:       pv = (cyc % 2) == 0;
                2:       pv = 1'($urandom_range(0, 1));
                default: pv = 1'b1;
            endcase
            if (midStart && expR == 2)
                applyStimulus(1'b1, 1'b0, pv, 7, 9);
            else
                applyStimulus(1'b0, 1'b0, pv, w, h);
            checkOutput({tag, "_ready"}, 32'(bus.pixel_ready), 1);
            if (pv) begin
                wv_q.push_back(expR >= 2 && expC >= 2);
                accepts++;
                if (expC == w - 1) begin
                    expC = 0;
                    expR++;
                end else begin
                    expC++;
                end
            end else begin
                wv_q.push_back(1'b0);
            end
            tick();
            if (wv_q.size() == 0) begin
                checkOutput({tag, "_sb_empty"}, 1, 0);
            end else begin
                expWv = wv_q.pop_front();
                checkOutput({tag, "_wv"}, 32'(bus.window_valid), 32'(expWv));
            end
            if (bus.window_valid === 1'b1) pulses++;
            if (accepts < w * h) begin
                checkOutput({tag, "_col"}, 32'(bus.col), expC);
                checkOutput({tag, "_row"}, 32'(bus.row), expR);
                checkOutput({tag, "_fd_early"}, 32'(bus.frame_done), 0);
            end else begin
                checkOutput({tag, "_done_fd"}, 32'(bus.frame_done), 1);
                checkOutput({tag, "_done_busy"}, 32'(bus.busy), 0);
                checkOutput({tag, "_done_col"}, 32'(bus.col), 0);
                checkOutput({tag, "_done_row"}, 32'(bus.row), 0);
            end
            cyc++;
        end
        if (accepts < w * h) checkOutput({tag, "_timeout_accepts"}, accepts, w * h);
        checkOutput({tag, "_pulses"}, pulses, (w - 2) * (h - 2));

        applyStimulus(1'b0, 1'b0, 1'b0, w, h);
        repeat (2) begin
            tick();
            checkOutput({tag, "_after_fd"}, 32'(bus.frame_done), 0);
            checkOutput({tag, "_after_busy"}, 32'(bus.busy), 0);
            checkOutput({tag, "_after_wv"}, 32'(bus.window_valid), 0);
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        n_rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);
        repeat (2) @(negedge clk);
        checkAll("reset", 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        n_rst = 1'b1;
        @(negedge clk);

        // Rejected configurations, then a minimal 4x3 frame.
        addVec(1, 0, 0, 2, 10, 0, 0, 0, 0, 0, 0, 1);
        addVec(0, 0, 0, 2, 10, 0, 0, 0, 0, 0, 0, 0);
        addVec(1, 0, 0, 10, 2, 0, 0, 0, 0, 0, 0, 1);
        addVec(0, 0, 0, 10, 2, 0, 0, 0, 0, 0, 0, 0);
        addVec(1, 0, 0, 4, 3, 1, 1, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 11; k++)
            addVec(0, 0, 1, 4, 3, 1, 1, k % 4, k / 4, k == 11, 0, 0);
        addVec(0, 0, 1, 4, 3, 0, 0, 0, 0, 1, 1, 0);
        addVec(0, 0, 0, 4, 3, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].start, vecs[i].abort, vecs[i].pv, int'(vecs[i].w), int'(vecs[i].h));
            tick();
            checkAll($sformatf("vec%0d", i), vecs[i].ready, vecs[i].busy, int'(vecs[i].col),
                     int'(vecs[i].row), vecs[i].wv, vecs[i].fd, vecs[i].err);
        end

        runFrame("toggle5x4", 5, 4, 1, 1'b0);
        runFrame("midstart6x5", 6, 5, 0, 1'b1);
        runFrame("rand7x5", 7, 5, 2, 1'b0);

        // Abort coinciding with the accept of pixel (row 2, col 3).
        applyStimulus(1'b1, 1'b0, 1'b0, 4, 3);
        tick();
        for (int k = 0; k < 11; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 4, 3);
            tick();
        end
        checkOutput("abort_pre_col", 32'(bus.col), 3);
        checkOutput("abort_pre_row", 32'(bus.row), 2);
        applyStimulus(1'b0, 1'b1, 1'b1, 4, 3);
        tick();
        checkAll("abort", 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4, 3);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkAll($sformatf("abort_post%0d", k), 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        end

        // Asynchronous reset in the middle of RUN, right after a window pulse.
        applyStimulus(1'b1, 1'b0, 1'b0, 6, 5);
        tick();
        for (int k = 0; k < 21; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 6, 5);
            tick();
        end
        checkOutput("rst_pre_col", 32'(bus.col), 3);
        checkOutput("rst_pre_row", 32'(bus.row), 3);
        checkOutput("rst_pre_wv", 32'(bus.window_valid), 1);
        #2;
        n_rst = 1'b0;
        #1;
        checkAll("rst_async", 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 6, 5);
        @(negedge clk);
        n_rst = 1'b1;
        repeat (2) begin
            tick();
            checkAll("rst_idle", 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        end
        runFrame("post_reset4x3", 4, 3, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
